// File: rtl/conv_out_serializer_if.sv
// AXI-Stream style bundle shared by the serializer's input and output sides.
// The master drives payload and valid; the slave answers with ready.
interface conv_out_serializer_if #(
    parameter int TDATA_W = 16
);
    logic [TDATA_W-1:0] tdata;
    logic               tvalid;
    logic               tlast;
    logic               tuser;
    logic               tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/conv_out_serializer.sv
// Convolution output serializer: takes one beat of CONV_CORES words from the
// convolution block and emits it one word per cycle, core 1 first, with an
// optional ReLU applied on the way out. The next beat is accepted in the same
// cycle the last word of the current beat leaves, so a steady stream runs at
// one word per clock with no bubbles.
module conv_out_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int CONV_CORES = 2
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          relu_en,
    conv_out_serializer_if.slave          s_axis,
    conv_out_serializer_if.master         m_axis
);

    localparam int                IDX_W    = (CONV_CORES > 1) ? $clog2(CONV_CORES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CONV_CORES - 1);

    typedef enum logic {
        ST_EMPTY,
        ST_SEND
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    last_q, last_d;
    logic                    user_q, user_d;
    logic [DATA_WIDTH-1:0]   words_q [CONV_CORES];
    logic [DATA_WIDTH-1:0]   words_d [CONV_CORES];

    logic                    s_ready;
    logic                    in_hs;
    logic                    out_hs;
    logic                    on_last_word;
    logic [DATA_WIDTH-1:0]   cur_word;

    // Negative words become zero when ReLU is on; no width change, no clamp.
    function automatic logic [DATA_WIDTH-1:0] apply_relu(
        input logic [DATA_WIDTH-1:0] w,
        input logic                  en
    );
        return (en && w[DATA_WIDTH-1]) ? '0 : w;
    endfunction

    // Handshake qualifiers and the lookahead ready for the input side.
    always_comb begin
        on_last_word = (idx_q == LAST_IDX);
        out_hs       = (state_q == ST_SEND) && m_axis.tready;
        // Ready is withheld during reset; otherwise it opens when empty or
        // when the final word of the held beat is leaving this cycle.
        s_ready      = !areset &&
                       ((state_q == ST_EMPTY) ||
                        ((state_q == ST_SEND) && on_last_word && m_axis.tready));
        in_hs        = s_axis.tvalid && s_ready;
    end

    assign s_axis.tready = s_ready;

    // Select the word addressed by idx without an array index, so the index
    // width never has to match the array bounds exactly.
    always_comb begin
        cur_word = '0;
        for (int i = 0; i < CONV_CORES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_word = words_q[i];
            end
        end
    end

    // Next-state, index and beat-register update.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        user_d  = user_q;
        words_d = words_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_hs) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_hs) begin
                    if (!on_last_word) begin
                        idx_d = idx_q + 1'b1;
                    end else if (!in_hs) begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // A new beat can only be accepted when the register is free, so a
        // load always restarts the word index at core 1.
        if (in_hs) begin
            idx_d  = '0;
            last_d = s_axis.tlast;
            user_d = s_axis.tuser;
            for (int i = 0; i < CONV_CORES; i++) begin
                words_d[i] = s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Control state with synchronous reset; a reset drops any remaining words.
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before this edge.
        if (areset) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            user_q  <= user_d;
        end
    end

    // Beat payload storage.
    always_ff @(posedge aclk) begin
        // NOTE: the payload is not reset; it is only observed in SEND, which
        // always follows a fresh load, and outputs are forced to zero otherwise.
        words_q <= words_d;
    end

    // Output stream: valid only in SEND, all payload fields zero when empty.
    always_comb begin
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = '0;
        m_axis.tlast  = 1'b0;
        m_axis.tuser  = 1'b0;
        if (state_q == ST_SEND) begin
            m_axis.tvalid = 1'b1;
            m_axis.tdata  = apply_relu(cur_word, relu_en);
            m_axis.tlast  = last_q && on_last_word;
            m_axis.tuser  = user_q;
        end
    end

endmodule

// File: tb/tb_conv_out_serializer.sv
// Directed testbench for conv_out_serializer: a 4-core instance covers the
// main scenarios, a 1-core instance covers the register-slice configuration.
module tb_conv_out_serializer;

    localparam int DW = 16;
    localparam int NC = 4;

    logic aclk;
    logic areset;
    logic relu_en;

    int checks;
    int errors;

    conv_out_serializer_if #(.TDATA_W(DW*NC)) s_axis ();
    conv_out_serializer_if #(.TDATA_W(DW))    m_axis ();
    conv_out_serializer_if #(.TDATA_W(DW))    sc_s_axis ();
    conv_out_serializer_if #(.TDATA_W(DW))    sc_m_axis ();

    conv_out_serializer #(.DATA_WIDTH(DW), .CONV_CORES(NC)) u_dut (
        .aclk    (aclk),
        .areset  (areset),
        .relu_en (relu_en),
        .s_axis  (s_axis),
        .m_axis  (m_axis)
    );

    conv_out_serializer #(.DATA_WIDTH(DW), .CONV_CORES(1)) u_dut_sc (
        .aclk    (aclk),
        .areset  (areset),
        .relu_en (relu_en),
        .s_axis  (sc_s_axis),
        .m_axis  (sc_m_axis)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Advance one clock; inputs change and outputs are read on the falling edge.
    task automatic step();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic test_reset();
        areset = 1'b1;
        step();
        step();
        #1;
        checks++;
        if (m_axis.tvalid !== 1'b0 || m_axis.tlast !== 1'b0 || m_axis.tuser !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got v=%b l=%b u=%b want 000", m_axis.tvalid, m_axis.tlast, m_axis.tuser);
        end
        checks++;
        if (m_axis.tdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data got %h want 0000", m_axis.tdata);
        end
        checks++;
        if (s_axis.tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready got %b want 0", s_axis.tready);
        end
        areset = 1'b0;
        #1;
        checks++;
        if (s_axis.tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_tready got %b want 1", s_axis.tready);
        end
    endtask

    task automatic test_single();
        m_axis.tready = 1'b1;
        s_axis.tdata  = 64'h0004_0003_0002_0001;
        s_axis.tlast  = 1'b1;
        s_axis.tuser  = 1'b1;
        s_axis.tvalid = 1'b1;
        #1;
        checks++;
        if (s_axis.tready !== 1'b1) begin
            errors++;
            $display("FAIL single_accept got tready=%b want 1", s_axis.tready);
        end
        step();
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tuser  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 16'(k + 1)) begin
                errors++;
                $display("FAIL single_word%0d got v=%b d=%h want v=1 d=%h", k, m_axis.tvalid, m_axis.tdata, 16'(k + 1));
            end
            checks++;
            if (m_axis.tlast !== (k == 3) || m_axis.tuser !== 1'b1) begin
                errors++;
                $display("FAIL single_side%0d got l=%b u=%b want l=%b u=1", k, m_axis.tlast, m_axis.tuser, (k == 3));
            end
            checks++;
            if (s_axis.tready !== (k == 3)) begin
                errors++;
                $display("FAIL single_tready%0d got %b want %b", k, s_axis.tready, (k == 3));
            end
            step();
        end
        #1;
        checks++;
        if (m_axis.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got v=%b want 0", m_axis.tvalid);
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        m_axis.tready = 1'b1;
        nb = 0;
        s_axis.tdata  = {16'd4, 16'd3, 16'd2, 16'd1};
        s_axis.tlast  = 1'b0;
        s_axis.tuser  = 1'b0;
        s_axis.tvalid = 1'b1;
        #1;
        checks++;
        if (s_axis.tready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_accept got %b want 1", s_axis.tready);
        end
        for (int j = 0; j <= 12; j++) begin
            if (j > 0) begin
                #1;
                checks++;
                if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 16'(j)) begin
                    errors++;
                    $display("FAIL b2b_word%0d got v=%b d=%h want v=1 d=%h", j - 1, m_axis.tvalid, m_axis.tdata, 16'(j));
                end
                checks++;
                if (m_axis.tlast !== (j == 12) || m_axis.tuser !== ((j - 1) / 4 == 1)) begin
                    errors++;
                    $display("FAIL b2b_side%0d got l=%b u=%b want l=%b u=%b", j - 1, m_axis.tlast, m_axis.tuser, (j == 12), ((j - 1) / 4 == 1));
                end
                checks++;
                if (s_axis.tready !== ((j - 1) % 4 == 3)) begin
                    errors++;
                    $display("FAIL b2b_tready%0d got %b want %b", j - 1, s_axis.tready, ((j - 1) % 4 == 3));
                end
            end
            if (s_axis.tvalid && s_axis.tready) begin
                step();
                nb++;
                if (nb < 3) begin
                    s_axis.tdata = {16'(nb*4 + 4), 16'(nb*4 + 3), 16'(nb*4 + 2), 16'(nb*4 + 1)};
                    s_axis.tlast = (nb == 2);
                    s_axis.tuser = (nb == 1);
                end else begin
                    s_axis.tvalid = 1'b0;
                    s_axis.tlast  = 1'b0;
                    s_axis.tuser  = 1'b0;
                end
            end else begin
                step();
            end
        end
        #1;
        checks++;
        if (m_axis.tvalid !== 1'b0 || nb !== 3) begin
            errors++;
            $display("FAIL b2b_end got v=%b beats=%0d want v=0 beats=3", m_axis.tvalid, nb);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_w [4];
        int          widx;
        int          c;
        logic        hs;
        exp_w[0] = 16'h0011;
        exp_w[1] = 16'h0022;
        exp_w[2] = 16'h0033;
        exp_w[3] = 16'h0044;
        m_axis.tready = 1'b0;
        s_axis.tdata  = 64'h0044_0033_0022_0011;
        s_axis.tvalid = 1'b1;
        step();
        s_axis.tvalid = 1'b0;
        widx = 0;
        c    = 0;
        while (widx < 4 && c < 40) begin
            m_axis.tready = (c % 3 == 0);
            #1;
            checks++;
            if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== exp_w[widx]) begin
                errors++;
                $display("FAIL bp_cycle%0d got v=%b d=%h want v=1 d=%h", c, m_axis.tvalid, m_axis.tdata, exp_w[widx]);
            end
            checks++;
            if (s_axis.tready !== (widx == 3 && m_axis.tready)) begin
                errors++;
                $display("FAIL bp_tready%0d got %b want %b", c, s_axis.tready, (widx == 3 && m_axis.tready));
            end
            hs = m_axis.tready;
            step();
            if (hs) widx++;
            c++;
        end
        checks++;
        if (widx !== 4) begin
            errors++;
            $display("FAIL bp_timeout got words=%0d want 4", widx);
        end
        #1;
        checks++;
        if (m_axis.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got v=%b want 0", m_axis.tvalid);
        end
    endtask

    task automatic test_relu();
        logic [15:0] exp_on  [4];
        logic [15:0] exp_off [4];
        exp_on[0]  = 16'h0005; exp_on[1]  = 16'h0000; exp_on[2]  = 16'h0000; exp_on[3]  = 16'h7FFF;
        exp_off[0] = 16'h0005; exp_off[1] = 16'hFFFF; exp_off[2] = 16'h8000; exp_off[3] = 16'h7FFF;
        m_axis.tready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            relu_en       = (pass == 0);
            s_axis.tdata  = {16'h7FFF, 16'h8000, 16'hFFFF, 16'h0005};
            s_axis.tvalid = 1'b1;
            step();
            s_axis.tvalid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                #1;
                checks++;
                if (m_axis.tdata !== (pass == 0 ? exp_on[k] : exp_off[k])) begin
                    errors++;
                    $display("FAIL relu%0d_word%0d got %h want %h", relu_en, k, m_axis.tdata, (pass == 0 ? exp_on[k] : exp_off[k]));
                end
                step();
            end
        end
        relu_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        m_axis.tready = 1'b1;
        s_axis.tdata  = 64'h0004_0003_0002_0001;
        s_axis.tvalid = 1'b1;
        step();
        s_axis.tvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (m_axis.tdata !== 16'(k + 1)) begin
                errors++;
                $display("FAIL rmid_word%0d got %h want %h", k, m_axis.tdata, 16'(k + 1));
            end
            step();
        end
        areset = 1'b1;
        step();
        #1;
        checks++;
        if (m_axis.tvalid !== 1'b0 || m_axis.tdata !== 16'h0000 || s_axis.tready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_in_reset got v=%b d=%h rdy=%b want v=0 d=0000 rdy=0", m_axis.tvalid, m_axis.tdata, s_axis.tready);
        end
        areset = 1'b0;
        #1;
        checks++;
        if (s_axis.tready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_release got rdy=%b want 1", s_axis.tready);
        end
        s_axis.tdata  = 64'h0008_0007_0006_0005;
        s_axis.tvalid = 1'b1;
        step();
        s_axis.tvalid = 1'b0;
        #1;
        checks++;
        if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 16'h0005) begin
            errors++;
            $display("FAIL rmid_new_beat got v=%b d=%h want v=1 d=0005", m_axis.tvalid, m_axis.tdata);
        end
        for (int k = 0; k < 4; k++) step();
    endtask

    task automatic test_single_core();
        sc_m_axis.tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                sc_s_axis.tdata  = 16'hA001 + 16'(k);
                sc_s_axis.tlast  = (k == 2);
                sc_s_axis.tvalid = 1'b1;
            end else begin
                sc_s_axis.tvalid = 1'b0;
                sc_s_axis.tlast  = 1'b0;
            end
            #1;
            if (k > 0) begin
                checks++;
                if (sc_m_axis.tvalid !== 1'b1 || sc_m_axis.tdata !== 16'hA000 + 16'(k)) begin
                    errors++;
                    $display("FAIL sc_word%0d got v=%b d=%h want v=1 d=%h", k, sc_m_axis.tvalid, sc_m_axis.tdata, 16'hA000 + 16'(k));
                end
                checks++;
                if (sc_m_axis.tlast !== (k == 3)) begin
                    errors++;
                    $display("FAIL sc_last%0d got %b want %b", k, sc_m_axis.tlast, (k == 3));
                end
            end
            checks++;
            if (sc_s_axis.tready !== 1'b1) begin
                errors++;
                $display("FAIL sc_tready%0d got %b want 1", k, sc_s_axis.tready);
            end
            step();
        end
        #1;
        checks++;
        if (sc_m_axis.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL sc_drain got v=%b want 0", sc_m_axis.tvalid);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        areset  = 1'b1;
        relu_en = 1'b0;
        s_axis.tdata     = '0;
        s_axis.tvalid    = 1'b0;
        s_axis.tlast     = 1'b0;
        s_axis.tuser     = 1'b0;
        m_axis.tready    = 1'b0;
        sc_s_axis.tdata  = '0;
        sc_s_axis.tvalid = 1'b0;
        sc_s_axis.tlast  = 1'b0;
        sc_s_axis.tuser  = 1'b0;
        sc_m_axis.tready = 1'b0;
        @(negedge aclk);

        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_relu();
        test_reset_mid();
        test_single_core();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_out_serializer.md
CONV_OUT_SERIALIZER -- requirements
Module: conv_out_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of one output word (two's complement).
REQ-002 SHALL have parameter CONV_CORES, default 2: words per input beat; supported values are 1 or more.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port relu_en, input, 1 bit: apply ReLU to each word; held static during a layer.
REQ-006 SHALL have port s_axis_tdata, input, DATA_WIDTH*CONV_CORES bits: {core n word, ..., core 1 word}, core 1 in the LSBs; driven by the convolution block output.
REQ-007 SHALL have port s_axis_tvalid, input, 1 bit: input beat valid.
REQ-008 SHALL have port s_axis_tlast, input, 1 bit: last input beat of the layer.
REQ-009 SHALL have port s_axis_tuser, input, 1 bit: max_mode flag of the beat.
REQ-010 SHALL have port s_axis_tready, output, 1 bit: block can accept a beat.
REQ-011 SHALL have port m_axis_tdata, output, DATA_WIDTH bits: one serialized word.
REQ-012 SHALL have port m_axis_tvalid, output, 1 bit: output word valid.
REQ-013 SHALL have port m_axis_tlast, output, 1 bit: final word of the layer.
REQ-014 SHALL have port m_axis_tuser, output, 1 bit: max_mode flag of the beat the word came from.
REQ-015 SHALL have port m_axis_tready, input, 1 bit: downstream ready.

Function
REQ-016 SHALL transfer data only on cycles where tvalid and tready are both high, on both ports.
REQ-017 SHALL hold one beat in a register of CONV_CORES words, together with its tlast and tuser, plus a word index idx that counts 0..CONV_CORES-1.
REQ-018 SHALL use two states:
- EMPTY: m_axis_tvalid = 0.
- SEND: m_axis_tvalid = 1, m_axis_tdata = word[idx].
REQ-019 SHALL drive s_axis_tready = (state == EMPTY) or (state == SEND and idx == CONV_CORES-1 and m_axis_tready), as combinational lookahead with no bubble between beats.
REQ-020 In EMPTY, an input handshake SHALL load the register, set idx = 0 and enter SEND; the first word is valid on the next cycle (latency 1).
REQ-021 In SEND, an output handshake with idx < CONV_CORES-1 SHALL increment idx.
REQ-022 In SEND, an output handshake with idx = CONV_CORES-1 SHALL do one of:
- with a simultaneous input handshake: reload the register, set idx = 0 and stay in SEND;
- otherwise: go to EMPTY.
REQ-023 In SEND with m_axis_tready low, m_axis_tdata, m_axis_tlast, m_axis_tuser and idx SHALL hold stable.
REQ-024 SHALL emit words in core order: core 1 first, core CONV_CORES last.
REQ-025 SHALL assert m_axis_tlast only on word idx = CONV_CORES-1 of a beat loaded with s_axis_tlast = 1.
REQ-026 m_axis_tuser SHALL equal the s_axis_tuser captured with the beat, for every word of that beat.
REQ-027 With relu_en = 1, a word whose MSB is 1 SHALL be output as 0; all other words pass unchanged; no width change and no saturation.
REQ-028 With CONV_CORES = 1, the block SHALL act as a one-entry register slice with full throughput.
REQ-029 Sustained throughput SHALL be one word per cycle while m_axis_tready = 1 and input is available.

Reset
REQ-030 While areset = 1 at a clock edge, the block SHALL set state = EMPTY, idx = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tuser = 0 and m_axis_tdata = 0.
REQ-031 Reset mid-beat SHALL discard any remaining words; s_axis_tready SHALL be 1 on the first cycle after reset is released.
REQ-032 During reset, s_axis_tready SHALL be 0.

Verification (DATA_WIDTH=16, CONV_CORES=4)
REQ-033 Single beat: s_axis_tdata=0x0004_0003_0002_0001, tlast=1, tuser=1, m_axis_tready=1 -> outputs 0x0001, 0x0002, 0x0003, 0x0004 on the 4 cycles after acceptance; tlast only with 0x0004; tuser=1 on all 4 words.
REQ-034 Back-to-back: 3 beats offered continuously with m_axis_tready=1 -> 12 consecutive valid words, no gap; s_axis_tready high only on acceptance and on each idx=3 cycle.
REQ-035 Backpressure: m_axis_tready toggles 1,0,0,1,... -> word sequence unchanged, no loss or duplication, and outputs stable while stalled.
REQ-036 ReLU: relu_en=1, beat {0x7FFF, 0x8000, 0xFFFF, 0x0005} -> outputs 0x0005, 0x0000, 0x0000, 0x7FFF; with relu_en=0 -> 0x0005, 0xFFFF, 0x8000, 0x7FFF.
REQ-037 Reset mid-beat: areset pulsed after 2 of 4 words -> m_axis_tvalid=0 the next cycle; a new beat 0x0008_0007_0006_0005 then yields 0x0005 first.
